// File: rtl/cell_plot_pkg.sv
// Shared types and constants for the cell plot engine: FSM states, colours and
// the queued changed-cell event.
package cell_plot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PAINT = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_GRID  = 3'b001;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] colour;
  } cell_event_t;

  localparam int EVENT_W = $bits(cell_event_t);

endpackage

// File: rtl/cell_event_fifo.sv
// Synchronous event FIFO with flush; head entry is visible on rdata while
// not empty.
module cell_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 19
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_LAST   = AW'(DEPTH - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == COUNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state flops use non-blocking assignments so all updates land together at the edge.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; only entries below count are ever read.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cell_plot_engine.sv
// Rasterises queued changed-cell events into CELL_PX square pixel blocks for
// vga_adapter, plus a whole-grid clear sweep. Optional: CELL_PLOT_GRID_LINES_EN.
module cell_plot_engine
  import cell_plot_pkg::*;
#(
  parameter int CELL_PX    = 4,
  parameter int GRID_W     = 4,
  parameter int GRID_H     = 4,
  parameter int X_ORIGIN   = 0,
  parameter int Y_ORIGIN   = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_cell_x,
  input  logic [7:0] in_cell_y,
  input  logic [2:0] in_colour,
  input  logic       clear,
  output logic [7:0] out_x,
  output logic [7:0] out_y,
  output logic [2:0] out_colour,
  output logic       plot,
  output logic       busy,
  output logic       drop
);

  localparam int SPAN_W = GRID_W * CELL_PX;
  localparam int SPAN_H = GRID_H * CELL_PX;
  localparam logic [4:0] OFS_LAST     = 5'(CELL_PX - 1);
  localparam logic [8:0] OFS_MASK     = 9'(CELL_PX - 1);
  localparam logic [8:0] SWEEP_X_LAST = 9'(SPAN_W - 1);
  localparam logic [8:0] SWEEP_Y_LAST = 9'(SPAN_H - 1);
`ifdef CELL_PLOT_GRID_LINES_EN
  localparam bit GRID_LINES = 1'b1;
`else
  localparam bit GRID_LINES = 1'b0;
`endif

  generate
    if (CELL_PX < 1 || CELL_PX > 16 || (CELL_PX & (CELL_PX - 1)) != 0 ||
        FIFO_DEPTH < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        X_ORIGIN + SPAN_W > 160 || Y_ORIGIN + SPAN_H > 120) begin : g_bad_params
      $error("cell_plot_engine: parameters do not fit the 160x120 framebuffer");
    end
  endgenerate

  // Right and bottom edge of every cell become grid lines when enabled.
  function automatic logic [2:0] pixel_colour(input logic [4:0] ox, input logic [4:0] oy,
                                              input logic [2:0] fill);
    return (GRID_LINES && (ox == OFS_LAST || oy == OFS_LAST)) ? COLOUR_GRID : fill;
  endfunction

  state_e      state_q, state_d;
  logic [8:0]  base_x_q, base_x_d, base_y_q, base_y_d;
  logic [2:0]  colour_q, colour_d;
  logic [4:0]  px_q, px_d, py_q, py_d;
  logic [8:0]  sx_q, sx_d, sy_q, sy_d;
  logic        clear_pending_q, clear_pending_d;
  logic [7:0]  out_x_q, out_x_d, out_y_q, out_y_d;
  logic [2:0]  out_colour_q, out_colour_d;
  logic        plot_q, plot_d, drop_q, drop_d;

  cell_event_t in_event, head;
  logic        fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty, enter_clear;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;

  assign in_event  = '{x: in_cell_x, y: in_cell_y, colour: in_colour};
  assign in_ready  = !fifo_full && !clear_pending_q && (state_q != ST_CLEAR);
  assign fifo_push = in_valid && in_ready;
  assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

  cell_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EVENT_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (in_event),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    colour_d     = colour_q;
    px_d         = px_q;
    py_d         = py_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_colour_d = out_colour_q;
    plot_d       = 1'b0;
    drop_d       = 1'b0;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    enter_clear  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clear_pending_q)  enter_clear = 1'b1;
        else if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        fifo_pop = 1'b1;
        if (9'(head.x) >= 9'(GRID_W) || 9'(head.y) >= 9'(GRID_H)) begin
          drop_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          base_x_d = 9'(X_ORIGIN) + 9'(head.x) * 9'(CELL_PX);
          base_y_d = 9'(Y_ORIGIN) + 9'(head.y) * 9'(CELL_PX);
          colour_d = head.colour;
          px_d     = '0;
          py_d     = '0;
          plot_d   = 1'b1;
          state_d  = ST_PAINT;
        end
      end
      ST_PAINT: begin
        if (px_q != OFS_LAST) begin
          px_d   = px_q + 1'b1;
          plot_d = 1'b1;
        end else if (py_q != OFS_LAST) begin
          px_d   = '0;
          py_d   = py_q + 1'b1;
          plot_d = 1'b1;
        end else if (clear_pending_q) begin
          enter_clear = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (sx_q != SWEEP_X_LAST) begin
          sx_d   = sx_q + 1'b1;
          plot_d = 1'b1;
        end else if (sy_q != SWEEP_Y_LAST) begin
          sx_d   = '0;
          sy_d   = sy_q + 1'b1;
          plot_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Entering the sweep flushes pending events and emits its first pixel at once.
    if (enter_clear) begin
      state_d    = ST_CLEAR;
      fifo_flush = 1'b1;
      sx_d       = '0;
      sy_d       = '0;
      plot_d     = 1'b1;
    end

    if (plot_d) begin
      if (state_d == ST_PAINT) begin
        out_x_d      = 8'(base_x_d + 9'(px_d));
        out_y_d      = 8'(base_y_d + 9'(py_d));
        out_colour_d = pixel_colour(px_d, py_d, colour_d);
      end else begin
        out_x_d      = 8'(9'(X_ORIGIN) + sx_d);
        out_y_d      = 8'(9'(Y_ORIGIN) + sy_d);
        out_colour_d = pixel_colour(5'(sx_d & OFS_MASK), 5'(sy_d & OFS_MASK), COLOUR_BLACK);
      end
    end

    if (enter_clear)                          clear_pending_d = 1'b0;
    else if (clear && state_q != ST_CLEAR)    clear_pending_d = 1'b1;
    else                                      clear_pending_d = clear_pending_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      base_x_q        <= '0;
      base_y_q        <= '0;
      colour_q        <= '0;
      px_q            <= '0;
      py_q            <= '0;
      sx_q            <= '0;
      sy_q            <= '0;
      clear_pending_q <= 1'b0;
      out_x_q         <= '0;
      out_y_q         <= '0;
      out_colour_q    <= '0;
      plot_q          <= 1'b0;
      drop_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_x_q        <= base_x_d;
      base_y_q        <= base_y_d;
      colour_q        <= colour_d;
      px_q            <= px_d;
      py_q            <= py_d;
      sx_q            <= sx_d;
      sy_q            <= sy_d;
      clear_pending_q <= clear_pending_d;
      out_x_q         <= out_x_d;
      out_y_q         <= out_y_d;
      out_colour_q    <= out_colour_d;
      plot_q          <= plot_d;
      drop_q          <= drop_d;
    end
  end

  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_colour = out_colour_q;
  assign plot       = plot_q;
  assign drop       = drop_q;

endmodule

// File: tb/tb_cell_plot_engine.sv
// Directed self-checking bench for cell_plot_engine at default parameters;
// honours CELL_PLOT_GRID_LINES_EN when defined.
module tb_cell_plot_engine;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] in_cell_x = '0;
  logic [7:0] in_cell_y = '0;
  logic [2:0] in_colour = '0;
  logic       in_ready, plot, busy, drop;
  logic [7:0] out_x, out_y;
  logic [2:0] out_colour;

  int total = 0;
  int bad   = 0;

  // Monitor state: every plotted pixel with the cycle it appeared in.
  int         cyc = 0;
  int         hs_cnt = 0;
  int         blk_cnt = 0;
  int         drop_cnt = 0;
  bit         chk_full = 1'b0;
  int         full_base = 0;
  logic       plot_prev = 1'b0;
  logic [7:0] cap_x [$];
  logic [7:0] cap_y [$];
  logic [2:0] cap_c [$];
  int         cap_t [$];

  logic [7:0] b2b_x [9] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
  logic [7:0] b2b_y [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd3, 8'd3};
  logic [2:0] b2b_c [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};

  cell_plot_engine dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cell_x  (in_cell_x),
    .in_cell_y  (in_cell_y),
    .in_colour  (in_colour),
    .clear      (clear),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_colour (out_colour),
    .plot       (plot),
    .busy       (busy),
    .drop       (drop)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc++;
    if (plot === 1'b1) begin
      cap_x.push_back(out_x);
      cap_y.push_back(out_y);
      cap_c.push_back(out_colour);
      cap_t.push_back(cyc);
      if (plot_prev !== 1'b1) blk_cnt++;
    end
    plot_prev = plot;
    if (drop === 1'b1) drop_cnt++;
    if (chk_full && (hs_cnt - blk_cnt - full_base) >= 8) begin
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL full_ready: in_ready=%b with 8 entries queued, expected 0", in_ready);
      end
    end
    if (in_valid === 1'b1 && in_ready === 1'b1) hs_cnt++;
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] exp_colour(input int ox, input int oy, input logic [2:0] c);
`ifdef CELL_PLOT_GRID_LINES_EN
    if (ox == 3 || oy == 3) return 3'b001;
`endif
    return c;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    step;
    step;
    total++;
    if (plot !== 1'b0) begin bad++; $display("FAIL reset_plot: got %b expected 0", plot); end
    total++;
    if (drop !== 1'b0) begin bad++; $display("FAIL reset_drop: got %b expected 0", drop); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    total++;
    if (out_x !== 8'd0 || out_y !== 8'd0 || out_colour !== 3'd0) begin
      bad++;
      $display("FAIL reset_outputs: got x=%0d y=%0d c=%b expected 0 0 000", out_x, out_y, out_colour);
    end
    reset = 1'b0;
    step;
  endtask

  // Pushes one event with the engine idle and checks latency, every pixel and the tail.
  task automatic test_single_block(input string name, input logic [7:0] cx,
                                   input logic [7:0] cy, input logic [2:0] c);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready: got %b expected 1", name, in_ready); end
    in_valid  = 1'b1;
    in_cell_x = cx;
    in_cell_y = cy;
    in_colour = c;
    step;
    in_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      total++;
      if (plot !== 1'b0) begin bad++; $display("FAIL %s_latency t+%0d: plot=%b expected 0", name, k, plot); end
      step;
    end
    for (int py = 0; py < 4; py++) begin
      for (int px = 0; px < 4; px++) begin
        total++;
        if (plot !== 1'b1 || out_x !== 8'(cx * 4 + px) || out_y !== 8'(cy * 4 + py) ||
            out_colour !== exp_colour(px, py, c)) begin
          bad++;
          $display("FAIL %s_pixel(%0d,%0d): got plot=%b x=%0d y=%0d c=%b expected 1 %0d %0d %b",
                   name, px, py, plot, out_x, out_y, out_colour, cx * 4 + px, cy * 4 + py,
                   exp_colour(px, py, c));
        end
        step;
      end
    end
    total++;
    if (plot !== 1'b0 || busy !== 1'b0 || out_x !== 8'(cx * 4 + 3) || out_y !== 8'(cy * 4 + 3)) begin
      bad++;
      $display("FAIL %s_tail: got plot=%b busy=%b x=%0d y=%0d expected 0 0 %0d %0d",
               name, plot, busy, out_x, out_y, cx * 4 + 3, cy * 4 + 3);
    end
  endtask

  task automatic test_single;
    test_single_block("single", 8'd1, 8'd2, 3'b111);
  endtask

  task automatic test_back_to_back;
    int i0;
    int n;
    i0        = cap_x.size();
    full_base = hs_cnt - blk_cnt;
    chk_full  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid  = 1'b1;
      in_cell_x = b2b_x[i];
      in_cell_y = b2b_y[i];
      in_colour = b2b_c[i];
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin step; n++; end
      step;
    end
    in_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 600) begin step; n++; end
    chk_full = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_timeout: busy=%b after %0d cycles", busy, n); end
    total++;
    if (cap_x.size() - i0 != 144) begin
      bad++;
      $display("FAIL b2b_count: got %0d plots expected 144", cap_x.size() - i0);
    end
    for (int i = 0; i < 9; i++) begin
      for (int py = 0; py < 4; py++) begin
        for (int px = 0; px < 4; px++) begin
          int k;
          k = i0 + i * 16 + py * 4 + px;
          total++;
          if (k >= cap_x.size()) begin
            bad++;
            $display("FAIL b2b_pixel ev%0d(%0d,%0d): missing", i, px, py);
          end else if (cap_x[k] !== 8'(b2b_x[i] * 4 + px) || cap_y[k] !== 8'(b2b_y[i] * 4 + py) ||
                       cap_c[k] !== exp_colour(px, py, b2b_c[i])) begin
            bad++;
            $display("FAIL b2b_pixel ev%0d(%0d,%0d): got x=%0d y=%0d c=%b expected %0d %0d %b", i, px, py,
                     cap_x[k], cap_y[k], cap_c[k], b2b_x[i] * 4 + px, b2b_y[i] * 4 + py,
                     exp_colour(px, py, b2b_c[i]));
          end
        end
      end
    end
    for (int k = 1; k < 144; k++) begin
      if (i0 + k < cap_t.size()) begin
        total++;
        if (cap_t[i0 + k] - cap_t[i0 + k - 1] != ((k % 16 == 0) ? 3 : 1)) begin
          bad++;
          $display("FAIL b2b_spacing %0d: got %0d cycles expected %0d", k,
                   cap_t[i0 + k] - cap_t[i0 + k - 1], (k % 16 == 0) ? 3 : 1);
        end
      end
    end
  endtask

  task automatic test_drop;
    int i0;
    int d0;
    int n;
    i0 = cap_x.size();
    d0 = drop_cnt;
    in_valid  = 1'b1;
    in_cell_x = 8'd4;
    in_cell_y = 8'd0;
    in_colour = 3'b010;
    step;
    in_cell_x = 8'd2;
    in_cell_y = 8'd1;
    in_colour = 3'b101;
    step;
    in_valid = 1'b0;
    step;
    total++;
    if (drop !== 1'b1 || plot !== 1'b0) begin
      bad++;
      $display("FAIL drop_pulse: got drop=%b plot=%b expected 1 0", drop, plot);
    end
    step;
    total++;
    if (drop !== 1'b0) begin bad++; $display("FAIL drop_width: got drop=%b expected 0", drop); end
    n = 0;
    while (busy === 1'b1 && n < 100) begin step; n++; end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL drop_timeout: busy=%b", busy); end
    total++;
    if (drop_cnt - d0 != 1) begin bad++; $display("FAIL drop_count: got %0d expected 1", drop_cnt - d0); end
    total++;
    if (cap_x.size() - i0 != 16) begin
      bad++;
      $display("FAIL drop_plots: got %0d expected 16", cap_x.size() - i0);
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (i0 + k >= cap_x.size()) begin
        bad++;
        $display("FAIL drop_next_pixel %0d: missing", k);
      end else if (cap_x[i0 + k] !== 8'(8 + k % 4) || cap_y[i0 + k] !== 8'(4 + k / 4) ||
                   cap_c[i0 + k] !== exp_colour(k % 4, k / 4, 3'b101)) begin
        bad++;
        $display("FAIL drop_next_pixel %0d: got x=%0d y=%0d c=%b expected %0d %0d %b", k, cap_x[i0 + k],
                 cap_y[i0 + k], cap_c[i0 + k], 8 + k % 4, 4 + k / 4, exp_colour(k % 4, k / 4, 3'b101));
      end
    end
  endtask

  task automatic test_clear;
    int i0;
    int n;
    int rdy_hi;
    i0 = cap_x.size();
    in_valid  = 1'b1;
    in_cell_x = 8'd0; in_cell_y = 8'd0; in_colour = 3'b110;
    step;
    in_cell_x = 8'd1; in_cell_y = 8'd1; in_colour = 3'b011;
    step;
    in_cell_x = 8'd2; in_cell_y = 8'd2; in_colour = 3'b100;
    step;
    in_cell_x = 8'd3; in_cell_y = 8'd3; in_colour = 3'b101;
    step;
    in_valid = 1'b0;
    repeat (3) step;
    total++;
    if (plot !== 1'b1 || out_x !== 8'd0 || out_y !== 8'd1) begin
      bad++;
      $display("FAIL clear_5th_pixel: got plot=%b x=%0d y=%0d expected 1 0 1", plot, out_x, out_y);
    end
    clear = 1'b1;
    step;
    clear = 1'b0;
    n = 0;
    rdy_hi = 0;
    while (busy === 1'b1 && n < 600) begin
      if (in_ready !== 1'b0) rdy_hi++;
      step;
      n++;
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL clear_timeout: busy=%b", busy); end
    total++;
    if (rdy_hi != 0) begin bad++; $display("FAIL clear_ready: high for %0d cycles expected 0", rdy_hi); end
    total++;
    if (cap_x.size() - i0 != 272) begin
      bad++;
      $display("FAIL clear_count: got %0d plots expected 272", cap_x.size() - i0);
    end
    for (int k = 0; k < 272; k++) begin
      logic [7:0] ex, ey;
      logic [2:0] ec;
      if (k < 16) begin
        ex = 8'(k % 4); ey = 8'(k / 4); ec = exp_colour(k % 4, k / 4, 3'b110);
      end else begin
        ex = 8'((k - 16) % 16); ey = 8'((k - 16) / 16);
        ec = exp_colour(((k - 16) % 16) % 4, ((k - 16) / 16) % 4, 3'b000);
      end
      total++;
      if (i0 + k >= cap_x.size()) begin
        bad++;
        $display("FAIL clear_pixel %0d: missing", k);
      end else if (cap_x[i0 + k] !== ex || cap_y[i0 + k] !== ey || cap_c[i0 + k] !== ec) begin
        bad++;
        $display("FAIL clear_pixel %0d: got x=%0d y=%0d c=%b expected %0d %0d %b", k, cap_x[i0 + k],
                 cap_y[i0 + k], cap_c[i0 + k], ex, ey, ec);
      end
    end
  endtask

  task automatic test_reset_mid;
    in_valid  = 1'b1;
    in_cell_x = 8'd2;
    in_cell_y = 8'd1;
    in_colour = 3'b011;
    step;
    in_valid = 1'b0;
    repeat (11) step;
    total++;
    if (plot !== 1'b1 || out_x !== 8'd9 || out_y !== 8'd6) begin
      bad++;
      $display("FAIL rstmid_10th_pixel: got plot=%b x=%0d y=%0d expected 1 9 6", plot, out_x, out_y);
    end
    reset = 1'b1;
    step;
    total++;
    if (plot !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_state: got plot=%b ready=%b busy=%b expected 0 1 0", plot, in_ready, busy);
    end
    reset = 1'b0;
    step;
    test_single_block("after_reset", 8'd3, 8'd2, 3'b100);
  endtask

`ifdef CELL_PLOT_GRID_LINES_EN
  task automatic test_grid_lines;
    int i0;
    i0 = cap_x.size();
    test_single_block("grid", 8'd1, 8'd2, 3'b111);
    total++;
    if (cap_x.size() < i0 + 16) begin
      bad++;
      $display("FAIL grid_capture: got %0d plots expected 16", cap_x.size() - i0);
    end else begin
      if (cap_x[i0 + 15] !== 8'd7 || cap_y[i0 + 15] !== 8'd11 || cap_c[i0 + 15] !== 3'b001) begin
        bad++;
        $display("FAIL grid_7_11: got x=%0d y=%0d c=%b expected 7 11 001",
                 cap_x[i0 + 15], cap_y[i0 + 15], cap_c[i0 + 15]);
      end
      total++;
      if (cap_x[i0 + 12] !== 8'd4 || cap_y[i0 + 12] !== 8'd11 || cap_c[i0 + 12] !== 3'b001) begin
        bad++;
        $display("FAIL grid_4_11: got x=%0d y=%0d c=%b expected 4 11 001",
                 cap_x[i0 + 12], cap_y[i0 + 12], cap_c[i0 + 12]);
      end
      total++;
      if (cap_x[i0 + 5] !== 8'd5 || cap_y[i0 + 5] !== 8'd9 || cap_c[i0 + 5] !== 3'b111) begin
        bad++;
        $display("FAIL grid_5_9: got x=%0d y=%0d c=%b expected 5 9 111",
                 cap_x[i0 + 5], cap_y[i0 + 5], cap_c[i0 + 5]);
      end
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_drop;
    test_clear;
    test_reset_mid;
`ifdef CELL_PLOT_GRID_LINES_EN
    test_grid_lines;
`endif
    step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cell_plot_engine.md
Name: cell_plot_engine

Overview:
Downstream stage between the life simulation core and vga_adapter. Accepts changed-cell events (cell x, cell y, colour) over a valid/ready handshake and buffers them in a small FIFO. Rasterises each event into a CELL_PX x CELL_PX pixel block on the 160x120 framebuffer, driving x/y/colour/plot one pixel per clock. Also provides a whole-grid clear sweep.

Parameters:
CELL_PX, 4, pixel edge length of one cell block; power of two, 1..16.
GRID_W, 4, cells per row; valid cell x is 0..GRID_W-1.
GRID_H, 4, cells per column; valid cell y is 0..GRID_H-1.
X_ORIGIN, 0, pixel x of the grid's top-left corner.
Y_ORIGIN, 0, pixel y of the grid's top-left corner.
FIFO_DEPTH, 8, number of event entries; power of two.

Ports:
clock  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high reset
in_valid  in  1  event present
in_ready  out  1  event accepted when in_valid & in_ready
in_cell_x  in  8  cell column
in_cell_y  in  8  cell row
in_colour  in  3  block colour (RGB, 1 bit each)
clear  in  1  single-cycle pulse requesting a clear sweep
out_x  out  8  pixel x to vga_adapter
out_y  out  8  pixel y to vga_adapter
out_colour  out  3  pixel colour to vga_adapter
plot  out  1  pixel write strobe
busy  out  1  high whenever the FSM is not in IDLE or the FIFO is not empty
drop  out  1  one-cycle pulse when a popped event is out of range

Behaviour:
- Clock and reset: one clock, "clock"; reset is synchronous and active-high.
- On reset: FIFO empty; FSM in IDLE; clear latch cleared; out_x = 0, out_y = 0, out_colour = 0, plot = 0, drop = 0, busy = 0, in_ready = 1.
- in_ready = !full && !clear_pending && state != CLEAR.
  - No bypass path; a simultaneous push and pop when full is not possible because ready is low.
  - Push and pop in the same cycle when not full are both honoured; count is unchanged.
- FSM states:
  - IDLE: if clear_pending, go to CLEAR. Otherwise, if the FIFO is not empty, go to LOAD.
  - LOAD: pop the head entry.
    - If cell_x >= GRID_W or cell_y >= GRID_H: pulse drop and return to IDLE.
    - Otherwise latch base_x = X_ORIGIN + cell_x*CELL_PX, base_y = Y_ORIGIN + cell_y*CELL_PX, and the colour. Zero the offsets px and py, then go to PAINT.
  - PAINT: each cycle, register out_x = base_x+px, out_y = base_y+py, out_colour = colour, plot = 1.
    - px increments fastest; it wraps at CELL_PX-1 and increments py.
    - After pixel (CELL_PX-1, CELL_PX-1) is issued: go to CLEAR if clear_pending, else go to IDLE.
  - CLEAR: flush the FIFO and drop the clear latch on entry. Sweep every pixel of the GRID_W*CELL_PX by GRID_H*CELL_PX area in raster order (x fastest) with colour 000 and plot = 1. Return to IDLE after the last pixel.
- Latency: with the FSM idle and the FIFO empty, a handshake in cycle t gives the first plot in cycle t+3 (t+1 IDLE sees non-empty, t+2 LOAD, t+3 first registered pixel).
  - One block takes exactly CELL_PX^2 consecutive plot cycles.
  - Back-to-back blocks have a 2-cycle gap (IDLE, LOAD) with plot = 0.
- Clear rules:
  - A clear pulse sets clear_pending.
  - A clear arriving mid-PAINT never truncates the current block.
  - A clear pulse during CLEAR is ignored.
- plot is low in IDLE, LOAD and the cycle after PAINT/CLEAR ends. out_x, out_y and out_colour hold their last values when plot is low.
- Arithmetic: pixel coordinates are computed in 9 bits and truncated to 8. Parameters must satisfy X_ORIGIN+GRID_W*CELL_PX <= 160 and Y_ORIGIN+GRID_H*CELL_PX <= 120, checked by an elaboration-time assertion.
- Reset mid-operation: in the following cycle plot = 0, the FIFO is empty and state is IDLE; the partial block is abandoned.

Optional Feature:
CELL_PLOT_GRID_LINES_EN
- Defined: during PAINT, pixels with px == CELL_PX-1 or py == CELL_PX-1 are plotted with colour 3'b001, giving a visible cell grid. Interior pixels use the event colour. During CLEAR, the same edge pixels are plotted 3'b001, not 000.
- Undefined: blocks are solid in the event colour and the clear sweep is all 000.

Decomposition:
- Package cell_plot_pkg holds:
  - the state enum (IDLE, LOAD, PAINT, CLEAR);
  - the colour constants COLOUR_BLACK = 3'b000 and COLOUR_GRID = 3'b001;
  - a packed event struct {x[7:0], y[7:0], colour[2:0]}.
- One sub-module: cell_event_fifo, a synchronous FIFO with push/pop, full/empty and count, parameterised on FIFO_DEPTH and the width of the event struct.

Test Plan:
- Push (1,2,3'b111), defaults -> starting 3 cycles after the handshake, 16 consecutive plots; x 4..7 fastest, y 8..11; colour 111; then busy falls.
- Hold in_valid for 9 distinct in-range events while the engine drains -> all 9 plotted in push order; 144 plot cycles; in_ready never high while the FIFO is full.
- Push (4,0,3'b010) -> no plot; drop high for exactly 1 cycle; the next queued event is plotted normally.
- Pulse clear in the 5th PAINT cycle of cell (0,0) with 3 events queued -> the block completes all 16 pixels; queued events are discarded; 256 plots of 000 cover x 0..15, y 0..15; in_ready stays low throughout.
- Assert reset during the 10th PAINT pixel -> the next cycle shows plot = 0, in_ready = 1, busy = 0; a new event is drawn correctly afterwards.
- With CELL_PLOT_GRID_LINES_EN, push (1,2,3'b111) -> pixel (7,11) and pixel (4,11) plotted 001; pixel (5,9) plotted 111.
